// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and the fetch FSM state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {ST_RUN, ST_STOP} fetch_state_t;

endpackage

// File: rtl/y86_instr_split.sv
// Combinational split of up to ten instruction bytes (byte0 in bits [7:0]) into fields.
module y86_instr_split
    import y86_pkg::*;
(
    input  logic [79:0] ibytes,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [3:0]  len,
    output logic        valid
);

    always_comb begin
        icode = ibytes[7:4];
        ifun  = ibytes[3:0];
        rA    = RNONE;
        rB    = RNONE;
        valC  = '0;
        len   = 4'd1;
        valid = 1'b1;
        case (icode)
            I_HALT, I_NOP, I_RET:         valid = (ifun == 4'd0);
            I_RRMOVQ:                     begin valid = (ifun <= 4'd6); len = 4'd2; end
            I_OPQ:                        begin valid = (ifun <= 4'd3); len = 4'd2; end
            I_PUSHQ, I_POPQ:              begin valid = (ifun == 4'd0); len = 4'd2; end
            I_JXX:                        begin valid = (ifun <= 4'd6); len = 4'd9; end
            I_CALL:                       begin valid = (ifun == 4'd0); len = 4'd9; end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin valid = (ifun == 4'd0); len = 4'd10; end
            default:                      valid = 1'b0;
        endcase
        // An invalid instruction occupies one byte and carries no operands.
        if (!valid)
            len = 4'd1;
        if (len == 4'd2 || len == 4'd10) begin
            rA = ibytes[15:12];
            rB = ibytes[11:8];
        end
        if (len == 4'd9)
            valC = ibytes[71:8];
        else if (len == 4'd10)
            valC = ibytes[79:16];
    end

endmodule

// File: rtl/y86_fetch.sv
// SEQ fetch stage: PC register, loadable byte instruction memory, field split and sticky status FSM.
module y86_fetch
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [7:0]        mem_wdata,
    input  logic              pc_en,
    input  logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [31:0]       icount
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] MEM_TOP = ADDR_W'(MEM_BYTES);

    logic [7:0]        mem [MEM_BYTES];
    logic [79:0]       ibytes;
    logic [3:0]        len;
    logic              valid;
    logic              adr_err;
    logic [2:0]        fetch_stat;
    logic [2:0]        sticky_stat, sticky_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic [31:0]       icount_nx;
    fetch_state_t      state, state_nx;

    // Memory is never reset; writes land even during reset or STOP.
    always_ff @(posedge clk) begin
        if (mem_we && mem_waddr < MEM_TOP)
            mem[mem_waddr[AW-1:0]] <= mem_wdata;
    end

    // Bytes past the end of memory read as zero; the ADR check flags them.
    for (genvar g = 0; g < 10; g++) begin : g_byte
        logic [ADDR_W-1:0] a;
        assign a = pc + ADDR_W'(g);
        assign ibytes[g*8 +: 8] = (a < MEM_TOP) ? mem[a[AW-1:0]] : 8'h00;
    end

    y86_instr_split u_split (
        .ibytes (ibytes),
        .icode  (icode),
        .ifun   (ifun),
        .rA     (rA),
        .rB     (rB),
        .valC   (valC),
        .len    (len),
        .valid  (valid)
    );

    // Written as pc > top-len so a huge pc cannot wrap past the bound.
    assign adr_err = pc > (MEM_TOP - ADDR_W'(len));
    assign valP    = pc + ADDR_W'(len);

    always_comb begin
        if (adr_err)               fetch_stat = S_ADR;
        else if (!valid)           fetch_stat = S_INS;
        else if (icode == I_HALT)  fetch_stat = S_HLT;
        else                       fetch_stat = S_AOK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            pc          <= '0;
            icount      <= '0;
            sticky_stat <= S_AOK;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            icount      <= icount_nx;
            sticky_stat <= sticky_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        icount_nx = icount;
        sticky_nx = sticky_stat;
        if (state == ST_RUN && pc_en) begin
            if (fetch_stat == S_AOK) begin
                pc_nx     = new_pc;
                icount_nx = icount + 32'd1;
            end else begin
                sticky_nx = fetch_stat;
                state_nx  = ST_STOP;
            end
        end
    end

    assign halted = (state == ST_STOP);
    assign stat   = halted ? sticky_stat : fetch_stat;

endmodule

// File: tb/tb_y86_fetch.sv
// Directed bench for y86_fetch: stimulus pushes expected snapshots, a negedge monitor compares them.
module tb_y86_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we;
    logic [63:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        pc_en;
    logic [63:0] new_pc;
    logic [63:0] pc;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] icount;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [2:0]  stat;
        logic        halted;
        logic [31:0] icount;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];

    y86_fetch #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .pc_en     (pc_en),
        .new_pc    (new_pc),
        .pc        (pc),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .valC      (valC),
        .valP      (valP),
        .stat      (stat),
        .halted    (halted),
        .icount    (icount)
    );

    always #5 clk = ~clk;

    // Monitor: stimulus pushes 1 time unit after a posedge, so every snapshot is checked at the next negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            snap_t e, g;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g = '{pc, icode, ifun, rA, rB, valC, valP, stat, halted, icount};
            tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL %s: got pc=%0h ic=%h fn=%h rA=%h rB=%h valC=%h valP=%0h stat=%0d h=%b cnt=%0d, expected pc=%0h ic=%h fn=%h rA=%h rB=%h valC=%h valP=%0h stat=%0d h=%b cnt=%0d",
                         n, g.pc, g.icode, g.ifun, g.ra, g.rb, g.valc, g.valp, g.stat, g.halted, g.icount,
                         e.pc, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.stat, e.halted, e.icount);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] a, input logic [7:0] d);
        mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
        step();
        mem_we = 1'b0;
    endtask

    task automatic wr_seq(input logic [63:0] a, input logic [79:0] d, input int n);
        for (int i = 0; i < n; i++)
            wr(a + 64'(i), d[i*8 +: 8]);
    endtask

    task automatic adv(input logic [63:0] npc);
        pc_en = 1'b1; new_pc = npc;
        step();
        pc_en = 1'b0;
    endtask

    task automatic ex(input string n, input logic [63:0] p, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                      input logic [2:0] st, input logic h, input logic [31:0] cnt);
        exp_q.push_back('{p, ic, fn, ra, rb, vc, vp, st, h, cnt});
        name_q.push_back(n);
    endtask

    initial begin
        reset = 1'b1; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0; pc_en = 1'b0; new_pc = '0;
        step();
        for (int i = 0; i < 1024; i++) wr(64'(i), 8'h00);
        ex("reset_state", 0, 4'h0, 4'h0, 4'hF, 4'hF, 0, 1, 3'd2, 1'b0, 0);

        // irmovq $10,%rdx at 0; OPq 60 23 at 10; halt at 12
        wr_seq(0, 80'h00_00_00_00_00_00_00_0A_F2_30, 10);
        wr(10, 8'h60); wr(11, 8'h23); wr(12, 8'h00);
        reset = 1'b0;
        ex("irmovq", 0, 4'h3, 4'h0, 4'hF, 4'h2, 10, 10, 3'd1, 1'b0, 0);
        adv(10);
        ex("opq", 10, 4'h6, 4'h0, 4'h2, 4'h3, 0, 12, 3'd1, 1'b0, 1);
        step();
        ex("hold", 10, 4'h6, 4'h0, 4'h2, 4'h3, 0, 12, 3'd1, 1'b0, 1);
        adv(12);
        ex("at_halt", 12, 4'h0, 4'h0, 4'hF, 4'hF, 0, 13, 3'd2, 1'b0, 2);
        adv(40);
        ex("halted", 12, 4'h0, 4'h0, 4'hF, 4'hF, 0, 13, 3'd2, 1'b1, 2);
        // STOP ignores pc_en but memory writes still land
        pc_en = 1'b1; new_pc = 0; mem_we = 1'b1; mem_waddr = 12; mem_wdata = 8'h10;
        step();
        pc_en = 1'b0; mem_we = 1'b0;
        ex("stop_sticky", 12, 4'h1, 4'h0, 4'hF, 4'hF, 0, 13, 3'd2, 1'b1, 2);

        reset = 1'b1; step(); reset = 1'b0;
        ex("reset_retains_mem", 0, 4'h3, 4'h0, 4'hF, 4'h2, 10, 10, 3'd1, 1'b0, 0);

        reset = 1'b1; wr(0, 8'hC0); reset = 1'b0;
        ex("ins_before", 0, 4'hC, 4'h0, 4'hF, 4'hF, 0, 1, 3'd4, 1'b0, 0);
        adv(5);
        ex("ins_after", 0, 4'hC, 4'h0, 4'hF, 4'hF, 0, 1, 3'd4, 1'b1, 0);

        reset = 1'b1; wr(0, 8'h10); reset = 1'b0;
        ex("nop_at0", 0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 1, 3'd1, 1'b0, 0);
        // write at current pc with pc_en: decision uses the old (nop) byte
        pc_en = 1'b1; new_pc = 1; mem_we = 1'b1; mem_waddr = 0; mem_wdata = 8'hC0;
        step();
        pc_en = 1'b0; mem_we = 1'b0;
        ex("write_same_cycle", 1, 4'hF, 4'h2, 4'hF, 4'hF, 0, 2, 3'd4, 1'b0, 1);

        reset = 1'b1;
        wr(0, 8'h10);
        wr(1020, 8'h70);
        wr(1036, 8'hC0);
        wr_seq(100, 80'h00_FF_FF_FF_FF_FF_FF_FF_F8_80, 9);
        reset = 1'b0;
        ex("nop_reload", 0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 1, 3'd1, 1'b0, 0);
        adv(12);
        ex("oob_write_ignored", 12, 4'h1, 4'h0, 4'hF, 4'hF, 0, 13, 3'd1, 1'b0, 1);
        adv(100);
        ex("call_neg_valc", 100, 4'h8, 4'h0, 4'hF, 4'hF, 64'hFFFF_FFFF_FFFF_FFF8, 109, 3'd1, 1'b0, 2);
        adv(1020);
        ex("adr_before", 1020, 4'h7, 4'h0, 4'hF, 4'hF, 0, 1029, 3'd3, 1'b0, 3);
        adv(0);
        ex("adr_after", 1020, 4'h7, 4'h0, 4'hF, 4'hF, 0, 1029, 3'd3, 1'b1, 3);

        // reset wins over a simultaneous pc_en
        reset = 1'b1; pc_en = 1'b1; new_pc = 99;
        step();
        reset = 1'b0; pc_en = 1'b0;
        ex("reset_vs_pc_en", 0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 1, 3'd1, 1'b0, 0);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/y86_fetch.md
Name: y86_fetch

Overview:
- SEQ fetch stage for the Y86-64 processor; sits directly upstream of decode.
- Holds the architectural PC register and a byte-addressable instruction memory with a load port.
- Splits the instruction at PC into icode/ifun/rA/rB/valC/valP, which feed decode and the later stages.
- Tracks processor status with a sticky halt state machine, and counts fetched instructions.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes (power of two).
- ADDR_W, 64, PC and address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_we  in  1  instruction-memory byte write enable (program load).
- mem_waddr  in  ADDR_W  load byte address.
- mem_wdata  in  8  load byte.
- pc_en  in  1  advance PC this cycle (one instruction retired).
- new_pc  in  ADDR_W  next PC from the PC-update stage.
- pc  out  ADDR_W  current PC register.
- icode  out  4  instruction code.
- ifun  out  4  function code.
- rA  out  4  register A, 4'hF if the instruction has no register byte.
- rB  out  4  register B, 4'hF if the instruction has no register byte.
- valC  out  64  signed constant, little-endian.
- valP  out  ADDR_W  pc + instruction length.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  out  1  sticky stop flag.
- icount  out  32  count of accepted pc_en advances.

Behaviour:
- Reset values:
  - pc=0, halted=0, sticky_stat=AOK, icount=0.
  - Memory contents are not cleared.
  - All decode outputs follow combinationally from pc=0.
- Memory write: registered; a byte written at edge N is visible to fetch outputs after edge N. Writes with mem_waddr >= MEM_BYTES are ignored.
- Split logic: combinational from the pc register and memory; zero added latency.
  - byte0 gives icode = [7:4] and ifun = [3:0].
  - Instruction lengths by icode:
    - 0 (halt), 1 (nop), 9 (ret): length 1.
    - 2 (rrmovq/cmov), 6 (OPq), A (pushq), B (popq): length 2; byte1 gives rA = [7:4], rB = [3:0].
    - 7 (jXX), 8 (call): length 9; valC = bytes 1..8.
    - 3 (irmovq), 4 (rmmovq), 5 (mrmovq): length 10; byte1 is the register byte; valC = bytes 2..9.
  - valC=0 for instructions with no constant.
  - valP = pc + length, modulo 2^ADDR_W.
- Validity rules:
  - icode C..F is invalid.
  - ifun must be 0..3 for OPq and 0..6 for jXX/cmov; for all other icodes ifun must be 0. Anything else is invalid.
  - Invalid instruction → fetch_stat = INS; length is treated as 1.
  - Address error: any byte pc..pc+length-1 >= MEM_BYTES gives fetch_stat = ADR. ADR takes priority over INS.
  - icode 0 with no error gives fetch_stat = HLT; otherwise AOK.
- State machine RUN / STOP:
  - RUN: stat = fetch_stat. On an edge with pc_en=1:
    - fetch_stat==AOK → pc<=new_pc, icount++.
    - otherwise → sticky_stat<=fetch_stat, halted<=1, state→STOP; pc and icount unchanged.
  - RUN with pc_en=0: hold.
  - STOP: stat = sticky_stat; pc_en, new_pc and mem_we fetch effects are ignored for the PC. Memory writes still occur. Exit only by reset.
- Simultaneous events:
  - A write to the byte at the current pc in the same cycle as pc_en: the status decision uses the pre-write byte.
  - reset together with pc_en or mem_we: reset wins for pc/state/icount; the memory write still completes.
- Wrap-around: icount wraps at 2^32.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (I_HALT..I_POPQ).
  - stat codes (S_AOK, S_HLT, S_ADR, S_INS).
  - RNONE = 4'hF.
- One sub-module, y86_instr_split: combinational byte0..byte9 → icode/ifun/rA/rB/valC/length/valid. Decode and the later stages reuse it.

Test Plan:
- Load irmovq $10,%rdx at addr 0: 30 F2 0A 00 00 00 00 00 00 00. → icode=3, ifun=0, rA=F, rB=2, valC=10, valP=10, stat=1.
- Pulse pc_en with new_pc=10, where bytes 60 23 sit at 10. → pc=10, icode=6, rA=2, rB=3, valP=12, icount=1.
- Byte 00 at 12; pc_en with new_pc=12, then pc_en with new_pc=40. → after the second edge halted=1, stat=2, pc=12, icount=2; further pc_en is ignored.
- Byte C0 at pc=0 (after reset), then pc_en. → stat=4 before the edge; halted=1 after; valP=1.
- Byte 70 (jmp) at MEM_BYTES-4 and pc steered there. → stat=3; after pc_en, halted=1 and sticky stat=3.
- Assert reset while in STOP. → next edge: pc=0, halted=0, icount=0, stat reflects byte0; memory retained.
